button_events: RTL and testbench

BUTTON_EVENTS -- requirements
Module: button_events

---
 rtl/button_events.sv | 117 +++++++++++
 tb/tb_button_events.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/button_events.sv
// Button event decoder: turns a debounced level into press, release,
// click, long-press and auto-repeat pulses, all registered.
module button_events #(
  parameter int LONG_CYCLES   = 100000000,
  parameter int REPEAT_CYCLES = 20000000,
  parameter int CW            = 27
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clean,
  output logic o_press,
  output logic o_release,
  output logic o_click,
  output logic o_long_press,
  output logic o_repeat,
  output logic o_held
);

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    LONG
  } state_t;

  localparam logic [CW-1:0] LC_LAST = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] RC_LAST = CW'(REPEAT_CYCLES - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;

  logic r_press, r_release, r_click;
  logic r_long, r_repeat, r_held;
  logic w_press, w_release, w_click;
  logic w_long, w_repeat;

  // Release wins over any count boundary hit in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_press     = 1'b0;
    w_release   = 1'b0;
    w_click     = 1'b0;
    w_long      = 1'b0;
    w_repeat    = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (i_clean) begin
          w_state_nxt = PRESSED;
          w_press     = 1'b1;
        end
      end
      PRESSED: begin
        if (!i_clean) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_release   = 1'b1;
          w_click     = 1'b1;
        end else if (r_cnt == LC_LAST) begin
          w_state_nxt = LONG;
          w_cnt_nxt   = '0;
          w_long      = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      LONG: begin
        if (!i_clean) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_release   = 1'b1;
        end else if (r_cnt == RC_LAST) begin
          w_cnt_nxt = '0;
          w_repeat  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_click   <= 1'b0;
      r_long    <= 1'b0;
      r_repeat  <= 1'b0;
      r_held    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_press   <= w_press;
      r_release <= w_release;
      r_click   <= w_click;
      r_long    <= w_long;
      r_repeat  <= w_repeat;
      r_held    <= (w_state_nxt != IDLE);
    end
  end

  assign o_press      = r_press;
  assign o_release    = r_release;
  assign o_click      = r_click;
  assign o_long_press = r_long;
  assign o_repeat     = r_repeat;
  assign o_held       = r_held;

endmodule

// File: tb/tb_button_events.sv
// Bench for button_events: directed scenarios with explicit edge-indexed
// expectations plus random holds against a press-age reference model.
module tb_button_events;

  localparam int L = 8;
  localparam int R = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clean = 1'b0;
  logic o_press, o_release, o_click;
  logic o_long_press, o_repeat, o_held;

  int checks = 0;
  int errors = 0;

  // Reference model: age of the current hold in edges since its press.
  bit m_hold = 1'b0;
  int m_age = 0;
  logic [5:0] exp_vec;
  logic p_press = 1'b0, p_release = 1'b0, p_click = 1'b0;
  logic p_long = 1'b0, p_repeat = 1'b0;

  logic [5:0] obs;
  assign obs = {o_press, o_release, o_click, o_long_press, o_repeat, o_held};

  button_events #(
    .LONG_CYCLES  (L),
    .REPEAT_CYCLES(R),
    .CW           (4)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_clean     (clean),
    .o_press     (o_press),
    .o_release   (o_release),
    .o_click     (o_click),
    .o_long_press(o_long_press),
    .o_repeat    (o_repeat),
    .o_held      (o_held)
  );

  always #5 clk = ~clk;

  task automatic drive_edge(input logic c);
    logic e_p, e_rl, e_c, e_l, e_r;
    bit ok;
    clean = c;
    @(posedge clk);
    {e_p, e_rl, e_c, e_l, e_r} = '0;
    if (rst) begin
      m_hold = 1'b0;
    end else if (!m_hold) begin
      if (c) begin
        m_hold = 1'b1;
        m_age = 0;
        e_p = 1'b1;
      end
    end else begin
      m_age++;
      if (!c) begin
        e_rl = 1'b1;
        e_c = (m_age <= L);
        m_hold = 1'b0;
      end else begin
        e_l = (m_age == L);
        e_r = (m_age > L) && (((m_age - L) % R) == 0);
      end
    end
    exp_vec = {e_p, e_rl, e_c, e_l, e_r, m_hold};
    #1;
    ok = ($countones({o_press, o_long_press, o_repeat}) <= 1)
      && !(o_press && (o_release || o_click))
      && !(o_press && p_press) && !(o_release && p_release)
      && !(o_click && p_click) && !(o_long_press && p_long)
      && !(o_repeat && p_repeat);
    checks++;
    assert (ok) else begin
      $display("FAIL pulse_excl_width t=%0t got %b", $time, obs);
      errors++;
    end
    {p_press, p_release, p_click, p_long, p_repeat} =
      {o_press, o_release, o_click, o_long_press, o_repeat};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clean = 1'b1;
    #1;
    checks++;
    if (obs !== 6'b0) begin
      $display("FAIL reset_async got %b want %b", obs, 6'b0);
      errors++;
    end
    for (int i = 0; i < 3; i++) begin
      drive_edge(1'b1);
      checks++;
      if (obs !== 6'b0) begin
        $display("FAIL reset_hold got %b want %b", obs, 6'b0);
        errors++;
      end
    end
    rst = 1'b0;
    drive_edge(1'b1);
    checks++;
    if (obs !== 6'b100001) begin
      $display("FAIL reset_e0_press got %b want %b", obs, 6'b100001);
      errors++;
    end
    drive_edge(1'b0);
    checks++;
    if (obs !== 6'b011000) begin
      $display("FAIL reset_e1_release got %b want %b", obs, 6'b011000);
      errors++;
    end
    drive_edge(1'b0);
  endtask

  task automatic test_short();
    logic [5:0] want;
    for (int i = 0; i <= 5; i++) begin
      drive_edge(i < 5);
      want = {i == 0, i == 5, i == 5, 1'b0, 1'b0, i < 5};
      checks++;
      if (obs !== want) begin
        $display("FAIL short E%0d got %b want %b", i, obs, want);
        errors++;
      end
    end
    drive_edge(1'b0);
  endtask

  task automatic test_long();
    logic [5:0] want;
    for (int i = 0; i <= 20; i++) begin
      drive_edge(i < 20);
      want = {i == 0, i == 20, 1'b0, i == 8, i == 12 || i == 16, i < 20};
      checks++;
      if (obs !== want) begin
        $display("FAIL long E%0d got %b want %b", i, obs, want);
        errors++;
      end
    end
    drive_edge(1'b0);
  endtask

  task automatic test_boundary();
    logic [5:0] want;
    for (int i = 0; i <= 8; i++) begin
      drive_edge(i < 8);
      want = {i == 0, i == 8, i == 8, 1'b0, 1'b0, i < 8};
      checks++;
      if (obs !== want) begin
        $display("FAIL boundary E%0d got %b want %b", i, obs, want);
        errors++;
      end
    end
    drive_edge(1'b0);
  endtask

  task automatic test_async_reset();
    logic [5:0] want;
    for (int i = 0; i <= 10; i++) begin
      drive_edge(1'b1);
      want = {i == 0, 1'b0, 1'b0, i == 8, 1'b0, 1'b1};
      checks++;
      if (obs !== want) begin
        $display("FAIL areset_hold E%0d got %b want %b", i, obs, want);
        errors++;
      end
    end
    #2;
    rst = 1'b1;
    m_hold = 1'b0;
    #1;
    checks++;
    if (obs !== 6'b0) begin
      $display("FAIL areset_midcycle got %b want %b", obs, 6'b0);
      errors++;
    end
    drive_edge(1'b1);
    checks++;
    if (obs !== 6'b0) begin
      $display("FAIL areset_no_release got %b want %b", obs, 6'b0);
      errors++;
    end
    rst = 1'b0;
    drive_edge(1'b1);
    checks++;
    if (obs !== 6'b100001) begin
      $display("FAIL areset_repress got %b want %b", obs, 6'b100001);
      errors++;
    end
    drive_edge(1'b0);
    drive_edge(1'b0);
  endtask

  task automatic test_back_to_back();
    logic [3:0] pat;
    logic [5:0] want;
    pat = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      drive_edge(pat[i]);
      want = pat[i] ? 6'b100001 : 6'b011000;
      checks++;
      if (obs !== want) begin
        $display("FAIL b2b E%0d got %b want %b", i, obs, want);
        errors++;
      end
    end
    drive_edge(1'b0);
  endtask

  task automatic test_random();
    int n, gap;
    for (int h = 0; h < 40; h++) begin
      n = $urandom_range(1, 26);
      gap = $urandom_range(0, 2);
      for (int i = 0; i <= n + gap; i++) begin
        drive_edge(i < n);
        checks++;
        if (obs !== exp_vec) begin
          $display("FAIL random h%0d E%0d got %b want %b", h, i, obs, exp_vec);
          errors++;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_short();
    test_long();
    test_boundary();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
